alu_shift_stage: RTL
====================

# alu_shift_stage

Two-stage pipelined shift execution stage for the lab ALU datapath: accepts a shift operation (SLL, SRL, SRA) with operands and a tag over a valid/ready handshake, computes it on the 32-bit barrel shifter structure (arithmetic right shifts through the existing `sra` block, logical shifts through an internal mux network), and delivers a registered result downstream with full backpressure. It sits between the decode/operand-read stage and the writeback/result arbiter.

## Interface
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers an operation.
- in_ready  out  1  stage accepts the operation this cycle.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- in_x  in  32  value to shift.
- in_y  in  32  shift amount; only bits [4:0] used.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_z  out  32  shift result.
- out_tag  out  TAG_W  tag of the operation in out_z.
- out_err  out  1  operation used op 11 (only with SHIFT_ILLEGAL_TRAP_EN; tied 0 otherwise).

## Operation
- Stage 1 (S1): registers op, x, y[4:0], tag, s1_valid on accept (in_valid && in_ready).
- Stage 2 (S2): registers shifter output, tag, err, s2_valid; drives out_* directly from S2 registers.
- Shift semantics, amount n = y[4:0] (0..31): SLL z = x << n, zero fill; SRL z = x >> n, zero fill; SRA z = x >> n, fill with x[31]. n = 0 returns x for all ops.
- SRA uses the existing `sra` module instance; SLL/SRL use one 5-layer 2:1-mux network (shift by 1,2,4,8,16), SLL via bit-reversal of input and output.
- Advance rules: S2 loads when !s2_valid || out_ready; S1 loads when !s1_valid || S2 loads. in_ready = !s1_valid || (!s2_valid || out_ready). out_ready does not combinationally depend on in_valid; in_ready depends combinationally on out_ready only.
- S1 moving to S2 with no new accept clears s1_valid; S2 draining with S1 empty clears s2_valid.
- Holding: while out_valid && !out_ready, out_z/out_tag/out_err stay stable.
- Simultaneous accept, S1→S2 transfer and S2 drain in one cycle is legal: full throughput, one op per cycle.
- Ordering strictly in-order; no reorder, no drop.

## Timing
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_z=0, out_tag=0, out_err=0; in_ready=1 in the cycle after reset deasserts (combinationally 1 while valids are 0).
- Latency: op accepted at edge k appears with out_valid=1 after edge k+1 (visible in cycle k+1→k+2 window) with no backpressure; 2 edges accept-to-output.
- Capacity: 2 operations in flight; with out_ready=0 for ≥2 cycles and continuous in_valid, in_ready drops after 2 accepts.
- rst asserted mid-operation: both stages flushed on that edge, in-flight ops discarded, no out_valid pulse for them.
- Inputs sampled only on accepting edges; changes on in_* while in_ready=0 are ignored.

## Configuration
- SHIFT_ILLEGAL_TRAP_EN defined: op 11 passes through pipeline with out_z = x unchanged and out_err=1.
- Undefined: op 11 decoded as SRA, out_err tied 0.

## Test plan
- Reset then SRA x=0x8000_0000, y=4, out_ready=1 -> out_z=0xF800_0000 two edges after accept, tag echoed.
- SLL x=0x0000_0001, y=31 -> 0x8000_0000; SRL x=0xFFFF_FFFF, y=0x0000_0024 (n=4) -> 0x0FFF_FFFF.
- Back-to-back 8 ops, out_ready=1 -> one result per cycle, in order, in_ready constantly 1.
- out_ready=0 with continuous in_valid -> exactly 2 accepts, in_ready=0, out_z stable; release -> both drain in order, then throughput resumes.
- op=11 x=0x1234_5678: with SHIFT_ILLEGAL_TRAP_EN -> out_z=0x1234_5678, out_err=1; without, y=8 -> 0x0012_3456, out_err=0.
- rst pulsed with 2 ops in flight -> out_valid=0 next cycle, no stale result ever emitted.

Source files
------------

// File: rtl/alu_shift_stage.sv
// ---------------------------------------------------------------------------
// alu_shift_stage
//
// Two-stage pipelined shift execution stage (SLL / SRL / SRA) for the lab ALU
// datapath. It sits between decode/operand-read and the writeback arbiter.
//
// Optional feature macro: SHIFT_ILLEGAL_TRAP_EN
//   defined   : op 2'b11 passes x through unchanged and raises out_err.
//   undefined : op 2'b11 is decoded as SRA and out_err is tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (flushes both stages)
//   in_valid   upstream offers an operation
//   in_ready   stage accepts the operation this cycle
//   in_op      2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 reserved
//   in_x       value to shift
//   in_y       shift amount, only bits [4:0] are used
//   in_tag     opaque tag, returned unchanged with the result
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_z      shift result
//   out_tag    tag belonging to out_z
//   out_err    operation used the reserved op (trap build only)
// ---------------------------------------------------------------------------

// Arithmetic right shift block shared with the rest of the ALU datapath.
module sra (
    input  logic [31:0] x,
    input  logic [4:0]  n,
    output logic [31:0] z
);
    assign z = $signed(x) >>> n;
endmodule

module alu_shift_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. Upstream may change in_* freely while in_ready is low; only
    // accepting edges sample them. out_* stay frozen while out_valid is high
    // and out_ready is low. in_ready depends combinationally on out_ready
    // (never on in_valid), so a full pipe still streams one op per cycle.

    // Stage 1 registers
    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [31:0]      s1_x;
    logic [4:0]       s1_n;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2 registers
    logic             s2_valid;
    logic [31:0]      s2_z;
    logic [TAG_W-1:0] s2_tag;

    // Advance controls
    logic s2_load;
    logic s1_load;
    logic accept;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Shifter datapath (combinational, between S1 and S2)
    // -----------------------------------------------------------------------
    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    logic [31:0] sra_z;

    sra u_sra (
        .x (s1_x),
        .n (s1_n),
        .z (sra_z)
    );

    // One right-shifting mux ladder serves both logical shifts: a left shift
    // is a right shift of the bit-reversed operand, reversed back afterwards.
    logic [31:0] lin, l1, l2, l3, l4, l5, log_z;

    always_comb begin
        lin   = (s1_op == OP_SLL) ? bit_rev(s1_x) : s1_x;
        l1    = s1_n[0] ? {1'b0,  lin[31:1]}  : lin;
        l2    = s1_n[1] ? {2'b0,  l1[31:2]}   : l1;
        l3    = s1_n[2] ? {4'b0,  l2[31:4]}   : l2;
        l4    = s1_n[3] ? {8'b0,  l3[31:8]}   : l3;
        l5    = s1_n[4] ? {16'b0, l4[31:16]}  : l4;
        log_z = (s1_op == OP_SLL) ? bit_rev(l5) : l5;
    end

    logic [31:0] res_z;
    logic        res_err;

    always_comb begin
        res_z   = sra_z;
        res_err = 1'b0;
        case (s1_op)
            OP_SLL:  res_z = log_z;
            OP_SRL:  res_z = log_z;
            OP_SRA:  res_z = sra_z;
            default: begin
`ifdef SHIFT_ILLEGAL_TRAP_EN
                res_z   = s1_x;
                res_err = 1'b1;
`else
                res_z   = sra_z;
                res_err = 1'b0;
`endif
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stage 1
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_x     <= '0;
            s1_n     <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            // Emptying when S1 moves on with nothing new arriving.
            s1_valid <= in_valid;
            if (accept) begin
                s1_op  <= in_op;
                s1_x   <= in_x;
                s1_n   <= in_y[4:0];
                s1_tag <= in_tag;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_z     <= '0;
            s2_tag   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_z   <= res_z;
                s2_tag <= s1_tag;
            end
        end
    end

`ifdef SHIFT_ILLEGAL_TRAP_EN
    logic s2_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_err <= 1'b0;
        end else if (s2_load && s1_valid) begin
            s2_err <= res_err;
        end
    end

    assign out_err = s2_err;
`else
    logic unused_err;
    assign unused_err = res_err;
    assign out_err    = 1'b0;
`endif

    assign out_valid = s2_valid;
    assign out_z     = s2_z;
    assign out_tag   = s2_tag;

endmodule
